// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush controller.
// The datapath drives hazard/request inputs; the controller returns hold, bubble, flush and mult/div status.
interface pipeline_ctrl_if;
    logic       if_stall_req;
    logic       mem_stall_req;
    logic       flush_req;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_rs_read_en;
    logic       id_rt_read_en;
    logic       ex_mem_read;
    logic [4:0] ex_reg_write_addr;
    logic       ex_md_start;
    logic       ex_md_is_div;
    logic [5:0] stall;
    logic       id_ex_bubble;
    logic       ex_mem_bubble;
    logic       flush;
    logic       md_busy;
    logic       md_done;
    logic       md_abort;

    modport master (
        output if_stall_req, mem_stall_req, flush_req,
        output id_rs_addr, id_rt_addr, id_rs_read_en, id_rt_read_en,
        output ex_mem_read, ex_reg_write_addr, ex_md_start, ex_md_is_div,
        input  stall, id_ex_bubble, ex_mem_bubble, flush, md_busy, md_done, md_abort
    );

    modport slave (
        input  if_stall_req, mem_stall_req, flush_req,
        input  id_rs_addr, id_rt_addr, id_rs_read_en, id_rt_read_en,
        input  ex_mem_read, ex_reg_write_addr, ex_md_start, ex_md_is_div,
        output stall, id_ex_bubble, ex_mem_bubble, flush, md_busy, md_done, md_abort
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage core, including the mult/div occupancy FSM.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles / flush_count performance counters.
module pipeline_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 34,
    parameter int CNT_WIDTH  = 6
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.slave    bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    localparam logic [CNT_WIDTH-1:0] MUL_LD = CNT_WIDTH'(MUL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_LD = CNT_WIDTH'(DIV_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

    md_state_t            state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, ld_val;
    logic                 abort_q, abort_nxt;
    logic                 luh, md_stall;
    logic [5:0]           stall_o;
    logic                 id_ex_bubble_o, ex_mem_bubble_o, flush_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            abort_q <= abort_nxt;
        end
    end

    assign ld_val = bus.ex_md_is_div ? DIV_LD : MUL_LD;

    // The start cycle is the first EX cycle, so the load value is occupancy-1;
    // a 1-cycle op (load value 0) skips BUSY entirely.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ex_md_start && !bus.flush_req) begin
                    cnt_nxt   = ld_val;
                    state_nxt = (ld_val == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (bus.flush_req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    abort_nxt = 1'b1;
                end else if (cnt <= ONE) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            DONE: begin
                if (bus.flush_req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    abort_nxt = 1'b1;
                end else if (!bus.mem_stall_req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign luh = bus.ex_mem_read && (bus.ex_reg_write_addr != 5'd0) &&
                 ((bus.id_rs_read_en && (bus.id_rs_addr == bus.ex_reg_write_addr)) ||
                  (bus.id_rt_read_en && (bus.id_rt_addr == bus.ex_reg_write_addr)));

    assign md_stall = (state == BUSY) || ((state == IDLE) && bus.ex_md_start);

    always_comb begin
        stall_o         = 6'b000000;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        flush_o         = 1'b0;
        if (!rst) begin
            if (bus.flush_req) begin
                flush_o = 1'b1;
            end else if (bus.mem_stall_req) begin
                stall_o = 6'b011111;
            end else if (md_stall) begin
                stall_o         = 6'b001111;
                ex_mem_bubble_o = 1'b1;
            end else if (luh) begin
                stall_o        = 6'b000111;
                id_ex_bubble_o = 1'b1;
            end else if (bus.if_stall_req) begin
                stall_o        = 6'b000011;
                id_ex_bubble_o = 1'b1;
            end
        end
    end

    assign bus.stall         = stall_o;
    assign bus.id_ex_bubble  = id_ex_bubble_o;
    assign bus.ex_mem_bubble = ex_mem_bubble_o;
    assign bus.flush         = flush_o;
    assign bus.md_busy       = !rst && (state == BUSY);
    assign bus.md_done       = !rst && (state == DONE);
    assign bus.md_abort      = !rst && abort_q;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_o[0]) stall_cycles <= stall_cycles + 32'd1;
            if (flush_o)    flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, hazards, mult/div timing, flush abort, priority.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if bus();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
    pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus),
                       .stall_cycles(stall_cycles), .flush_count(flush_count));
`else
    pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {20'd0, bus.stall, bus.id_ex_bubble, bus.ex_mem_bubble, bus.flush,
                bus.md_busy, bus.md_done, bus.md_abort};
    endfunction

    function automatic logic [31:0] e(input logic [5:0] s, input logic idb, input logic exb,
                                      input logic fl, input logic busy, input logic done,
                                      input logic ab);
        return {20'd0, s, idb, exb, fl, busy, done, ab};
    endfunction

    task automatic idle_in();
        bus.if_stall_req      = 1'b0;
        bus.mem_stall_req     = 1'b0;
        bus.flush_req         = 1'b0;
        bus.id_rs_addr        = 5'd0;
        bus.id_rt_addr        = 5'd0;
        bus.id_rs_read_en     = 1'b0;
        bus.id_rt_read_en     = 1'b0;
        bus.ex_mem_read       = 1'b0;
        bus.ex_reg_write_addr = 5'd0;
        bus.ex_md_start       = 1'b0;
        bus.ex_md_is_div      = 1'b0;
    endtask

    logic [31:0] x;

    initial begin
        // reset with every request asserted
        rst = 1'b1;
        bus.if_stall_req = 1'b1; bus.mem_stall_req = 1'b1; bus.flush_req = 1'b1;
        bus.id_rs_addr = 5'd5; bus.id_rt_addr = 5'd5;
        bus.id_rs_read_en = 1'b1; bus.id_rt_read_en = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_reg_write_addr = 5'd5;
        bus.ex_md_start = 1'b1; bus.ex_md_is_div = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_hold", obs(), 32'd0);
        end
        @(negedge clk); rst = 1'b0; idle_in(); #1;
        chk("rst_release", obs(), 32'd0);

        // load-use hazards
        @(negedge clk); idle_in();
        bus.ex_mem_read = 1'b1; bus.ex_reg_write_addr = 5'd5;
        bus.id_rs_addr = 5'd5; bus.id_rs_read_en = 1'b1; #1;
        chk("luh_rs", obs(), e(6'b000111, 1, 0, 0, 0, 0, 0));
        @(negedge clk); bus.id_rs_read_en = 1'b0;
        bus.id_rt_addr = 5'd5; bus.id_rt_read_en = 1'b1; #1;
        chk("luh_rt", obs(), e(6'b000111, 1, 0, 0, 0, 0, 0));
        @(negedge clk); bus.id_rs_read_en = 1'b1; bus.id_rs_addr = 5'd0;
        bus.id_rt_addr = 5'd0; bus.ex_reg_write_addr = 5'd0; #1;
        chk("luh_r0", obs(), 32'd0);
        @(negedge clk); bus.ex_reg_write_addr = 5'd7; bus.id_rs_addr = 5'd7;
        bus.ex_mem_read = 1'b0; #1;
        chk("no_load", obs(), 32'd0);
        @(negedge clk); idle_in(); bus.if_stall_req = 1'b1; #1;
        chk("if_stall", obs(), e(6'b000011, 1, 0, 0, 0, 0, 0));

        // multiply, 2 cycles
        @(negedge clk); idle_in(); bus.ex_md_start = 1'b1; #1;
        chk("mul_c0", obs(), e(6'b001111, 0, 1, 0, 0, 0, 0));
        @(negedge clk); #1;
        chk("mul_c1", obs(), e(6'b001111, 0, 1, 0, 1, 0, 0));
        @(negedge clk); #1;
        chk("mul_c2", obs(), e(6'b000000, 0, 0, 0, 0, 1, 0));
        @(negedge clk); bus.ex_md_start = 1'b0; #1;
        chk("mul_c3", obs(), 32'd0);

        // divide with mem stall on cycles 33-35
        for (int c = 0; c <= 37; c++) begin
            @(negedge clk); idle_in();
            bus.ex_md_start   = (c <= 36);
            bus.ex_md_is_div  = 1'b1;
            bus.mem_stall_req = (c >= 33 && c <= 35);
            #1;
            if (c == 0)       x = e(6'b001111, 0, 1, 0, 0, 0, 0);
            else if (c <= 32) x = e(6'b001111, 0, 1, 0, 1, 0, 0);
            else if (c == 33) x = e(6'b011111, 0, 0, 0, 1, 0, 0);
            else if (c <= 35) x = e(6'b011111, 0, 0, 0, 0, 1, 0);
            else if (c == 36) x = e(6'b000000, 0, 0, 0, 0, 1, 0);
            else              x = 32'd0;
            chk($sformatf("div_c%0d", c), obs(), x);
        end

        // flush at cycle 10 of a divide, restart at 11
        for (int c = 0; c <= 46; c++) begin
            @(negedge clk); idle_in();
            bus.ex_md_start  = (c <= 45);
            bus.ex_md_is_div = 1'b1;
            bus.flush_req    = (c == 10);
            #1;
            if (c == 0)       x = e(6'b001111, 0, 1, 0, 0, 0, 0);
            else if (c <= 9)  x = e(6'b001111, 0, 1, 0, 1, 0, 0);
            else if (c == 10) x = e(6'b000000, 0, 0, 1, 1, 0, 0);
            else if (c == 11) x = e(6'b001111, 0, 1, 0, 0, 0, 1);
            else if (c <= 44) x = e(6'b001111, 0, 1, 0, 1, 0, 0);
            else if (c == 45) x = e(6'b000000, 0, 0, 0, 0, 1, 0);
            else              x = 32'd0;
            chk($sformatf("flush_c%0d", c), obs(), x);
        end

        // priority ladder
        @(negedge clk); idle_in();
        bus.flush_req = 1'b1; bus.mem_stall_req = 1'b1; bus.if_stall_req = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_reg_write_addr = 5'd9;
        bus.id_rt_addr = 5'd9; bus.id_rt_read_en = 1'b1; #1;
        chk("prio_flush", obs(), e(6'b000000, 0, 0, 1, 0, 0, 0));
        @(negedge clk); bus.flush_req = 1'b0; #1;
        chk("prio_mem", obs(), e(6'b011111, 0, 0, 0, 0, 0, 0));
        @(negedge clk); bus.mem_stall_req = 1'b0; #1;
        chk("prio_luh", obs(), e(6'b000111, 1, 0, 0, 0, 0, 0));
        @(negedge clk); bus.ex_mem_read = 1'b0; #1;
        chk("prio_if", obs(), e(6'b000011, 1, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
